// File: rtl/xaui_pkg.sv
// ---------------------------------------------------------------------------
// xaui_pkg
// Shared constants for the XAUI transmit idle generator: XGMII/8b10b
// character codes, lane and column counts, PRBS7 seed and the minimum
// ||A|| spacing. Also provides the PRBS7 step and the control-character
// legality test used by the encoder.
// ---------------------------------------------------------------------------
package xaui_pkg;

    localparam int LANES = 4;   // lanes per XAUI port
    localparam int COLS  = 2;   // XGMII columns per xaui_clk cycle

    localparam logic [7:0] CH_IDLE = 8'h07;
    localparam logic [7:0] CH_S    = 8'hFB;
    localparam logic [7:0] CH_T    = 8'hFD;
    localparam logic [7:0] CH_Q    = 8'h9C;
    localparam logic [7:0] CH_E    = 8'hFE;
    localparam logic [7:0] CH_A    = 8'h7C;   // K28.3
    localparam logic [7:0] CH_K    = 8'hBC;   // K28.5
    localparam logic [7:0] CH_R    = 8'h1C;   // K28.0

    localparam logic [6:0] PRBS_SEED     = 7'h7F;
    // Reset value of a_cnt and the base of every reload (16 + prbs[3:0]).
    localparam logic [4:0] A_SPACING_MIN = 5'd16;

    // One step of the x^7 + x^6 + 1 Fibonacci LFSR.
    function automatic logic [6:0] prbs7_step(input logic [6:0] s);
        return {s[5:0], s[6] ^ s[5]};
    endfunction

    // Control characters the MAC may legitimately send.
    function automatic logic is_legal_ctrl(input logic [7:0] b);
        return b inside {CH_IDLE, CH_S, CH_T, CH_Q, CH_E};
    endfunction

endpackage

// File: rtl/xaui_tx_prbs7.sv
// ---------------------------------------------------------------------------
// xaui_tx_prbs7
// PRBS7 (x^7 + x^6 + 1) source advancing two steps per clock, one per
// XGMII column. Both post-step values are exposed so the encoder can use
// the column-0 value for column 0 and the column-1 value for column 1.
//
// Ports:
//   clk        in   clock (rising edge)
//   reset      in   synchronous, active-high; reloads the seed
//   prbs_col0  out  LFSR value after the column-0 step
//   prbs_col1  out  LFSR value after the column-1 step (next state)
// ---------------------------------------------------------------------------
module xaui_tx_prbs7
    import xaui_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    output logic [6:0] prbs_col0,
    output logic [6:0] prbs_col1
);

    logic [6:0] state;

    assign prbs_col0 = prbs7_step(state);
    assign prbs_col1 = prbs7_step(prbs_col0);

    // NOTE: registers are written with non-blocking assignments so every
    // flop samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= PRBS_SEED;
        end else begin
            state <= prbs_col1;
        end
    end

endmodule

// File: rtl/xaui_tx_idle_gen.sv
// ---------------------------------------------------------------------------
// xaui_tx_idle_gen
// XAUI transmit column encoder for one 4-lane port. Two XGMII columns per
// cycle are registered, classified and encoded into the per-lane 8b/10b
// character stream. Idle columns and the IDLE tail of a T column become
// ||A||, ||K|| or ||R||; ||A|| is spaced 16..31 columns apart by a
// PRBS7-seeded down counter. Illegal control bytes become E and pulse
// code_err. Latency is two cycles (input register, encode register).
//
// Build option XAUI_TX_IDLE_RAND_EN: when defined, non-A fill columns pick
// K or R from the PRBS LSB; otherwise they are always K. The LFSR and the
// A spacing are the same in both builds.
//
// Ports:
//   xaui_clk       in   clock (rising edge)
//   reset          in   synchronous, active-high
//   xgmii_txd      in   [31:0] column 0, [63:32] column 1; byte n = lane n
//   xgmii_txc      in   control flag per byte of xgmii_txd
//   mgt_txdata     out  lane l at [16l+15:16l]; low byte column 0
//   mgt_txcharisk  out  lane l at [2l+1:2l]; low bit column 0
//   code_err       out  one-cycle pulse aligned with the offending output
// ---------------------------------------------------------------------------
module xaui_tx_idle_gen
    import xaui_pkg::*;
(
    input  logic        xaui_clk,
    input  logic        reset,
    input  logic [63:0] xgmii_txd,
    input  logic [7:0]  xgmii_txc,
    output logic [63:0] mgt_txdata,
    output logic [7:0]  mgt_txcharisk,
    output logic        code_err
);

    logic [63:0] txd_q;
    logic [7:0]  txc_q;
    logic [4:0]  a_cnt;
    logic [4:0]  a_cnt_next;
    logic [6:0]  prbs_col0;
    logic [6:0]  prbs_col1;
    logic [63:0] enc_data;
    logic [7:0]  enc_k;
    logic        enc_err;
    logic        prbs_unused;

    xaui_tx_prbs7 u_prbs (
        .clk       (xaui_clk),
        .reset     (reset),
        .prbs_col0 (prbs_col0),
        .prbs_col1 (prbs_col1)
    );

    // Only the low nibble feeds the encoder.
    assign prbs_unused = ^{prbs_col0[6:4], prbs_col1[6:4]};

    // NOTE: every variable written here gets a value before any branch, so
    // no path leaves one unassigned and no latch is inferred.
    always_comb begin
        logic [4:0] cnt;
        logic [3:0] nib;
        logic [7:0] b;
        logic [7:0] fill_code;
        logic       is_ctrl;
        logic       idle_col;
        logic       t_fill;
        logic       seen_t;

        enc_data  = '0;
        enc_k     = '0;
        enc_err   = 1'b0;
        cnt       = a_cnt;
        nib       = '0;
        b         = '0;
        fill_code = CH_K;
        is_ctrl   = 1'b0;
        idle_col  = 1'b0;
        t_fill    = 1'b0;
        seen_t    = 1'b0;

        for (int col = 0; col < COLS; col++) begin
            nib = (col == 0) ? prbs_col0[3:0] : prbs_col1[3:0];

            // Classify: all-IDLE column, or T followed by at least one IDLE.
            idle_col = 1'b1;
            t_fill   = 1'b0;
            seen_t   = 1'b0;
            for (int lane = 0; lane < LANES; lane++) begin
                b       = txd_q[col*32 + lane*8 +: 8];
                is_ctrl = txc_q[col*LANES + lane];
                if (!(is_ctrl && b == CH_IDLE)) idle_col = 1'b0;
                if (is_ctrl && b == CH_IDLE && seen_t) t_fill = 1'b1;
                if (is_ctrl && b == CH_T) seen_t = 1'b1;
            end

            // The counter is tested before it moves: a fill column seeing 0
            // emits A and reloads, everything else counts down to 0 and waits.
            if ((idle_col || t_fill) && cnt == 5'd0) begin
                fill_code = CH_A;
                cnt       = A_SPACING_MIN + {1'b0, nib};
            end else begin
`ifdef XAUI_TX_IDLE_RAND_EN
                fill_code = nib[0] ? CH_R : CH_K;
`else
                fill_code = CH_K;
`endif
                if (cnt != 5'd0) cnt = cnt - 5'd1;
            end

            seen_t = 1'b0;
            for (int lane = 0; lane < LANES; lane++) begin
                b       = txd_q[col*32 + lane*8 +: 8];
                is_ctrl = txc_q[col*LANES + lane];
                enc_k[lane*2 + col] = is_ctrl;
                if (!is_ctrl) begin
                    enc_data[lane*16 + col*8 +: 8] = b;
                end else if (b == CH_IDLE) begin
                    // IDLE is only meaningful in an idle column or after T.
                    if (idle_col || seen_t) begin
                        enc_data[lane*16 + col*8 +: 8] = fill_code;
                    end else begin
                        enc_data[lane*16 + col*8 +: 8] = CH_E;
                        enc_err = 1'b1;
                    end
                end else if (is_legal_ctrl(b)) begin
                    enc_data[lane*16 + col*8 +: 8] = b;
                    if (b == CH_T) seen_t = 1'b1;
                end else begin
                    enc_data[lane*16 + col*8 +: 8] = CH_E;
                    enc_err = 1'b1;
                end
            end
        end

        a_cnt_next = cnt;
    end

    always_ff @(posedge xaui_clk) begin
        if (reset) begin
            // All-IDLE input register makes fill generation start right away.
            txd_q         <= {8{CH_IDLE}};
            txc_q         <= '1;
            a_cnt         <= A_SPACING_MIN;
            mgt_txdata    <= {8{CH_K}};
            mgt_txcharisk <= '1;
            code_err      <= 1'b0;
        end else begin
            txd_q         <= xgmii_txd;
            txc_q         <= xgmii_txc;
            a_cnt         <= a_cnt_next;
            mgt_txdata    <= enc_data;
            mgt_txcharisk <= enc_k;
            code_err      <= enc_err;
        end
    end

endmodule
